prog_delay_line: RTL

Run-time programmable, multi-bit delay line. It is the parametrised successor of the fixed single-bit delay line. Each enabled cycle it carries a WIDTH-bit sample plus a valid flag through a ring buffer, and the delay is selectable per run from 1 to MAX_DELAY. It is used for aligning data/strobe paths in the 12 MHz fabric where the alignment is set by software or configuration.

---
 rtl/prog_delay_line_pkg.sv | 45 ++++
 rtl/prog_delay_line_ring_ram.sv | 76 +++++++
 rtl/prog_delay_line.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/prog_delay_line_pkg.sv
`default_nettype none
// ============================================================================
// Package     : pdl_defs
// Description : Shared definitions for the programmable delay line.
//               - FSM state encoding
//               - clog2 helper
//               - delay clamp helper
// Revision    : 1.0 - initial release
// ============================================================================
package pdl_defs;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } pdl_state_e;

  // Ceiling log2. The argument must be at least 1; pdl_clog2(1) returns 0.
  function automatic int pdl_clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >>> 1;
    end
    return result;
  endfunction

  // Maps a requested delay onto the supported range 1..max_d.
  // A request of 0 behaves as 1; anything above max_d behaves as max_d.
  function automatic int unsigned pdl_clamp(input int unsigned req,
                                            input int unsigned max_d);
    if (req == 0) begin
      return 1;
    end
    if (req > max_d) begin
      return max_d;
    end
    return req;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_delay_line_ring_ram.sv
`default_nettype none
// ============================================================================
// Module      : pdl_ring_ram
// Description : DEPTH x (WIDTH+1) register file backing the delay line.
//               - Synchronous write of one data word and its valid flag.
//               - Registered read, read-before-write: a read and a write to
//                 the same entry at one edge returns the old contents.
//               - clr_valid drops every stored valid flag at once; it takes
//                 precedence over a simultaneous write.
//               - rd_clr loads zero into the read register; rd_en loads the
//                 addressed entry; neither asserted holds the register.
//               - Read data is zeroed whenever the stored flag is 0.
// Ports       : clk, rst_n          clock, async active-low reset
//               wr_en/wr_idx        write strobe and index
//               wr_data/wr_valid    word and qualifier to store
//               clr_valid           clear all stored valid flags
//               rd_en/rd_clr/rd_idx read register load / zero / index
//               rd_data/rd_valid    registered read result
// Revision    : 1.0 - initial release
// ============================================================================
module pdl_ring_ram
  import pdl_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = pdl_clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_idx,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_valid,
  input  logic             clr_valid,
  input  logic             rd_en,
  input  logic             rd_clr,
  input  logic [AW-1:0]    rd_idx,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid
);

  // Data words carry no reset: they are only ever observed through a flag.
  logic [WIDTH-1:0] data_mem [DEPTH];
  logic [DEPTH-1:0] valid_mem;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_mem[wr_idx] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_mem <= '0;
    end else if (clr_valid) begin
      valid_mem <= '0;
    end else if (wr_en) begin
      valid_mem[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_clr) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_en) begin
      rd_valid <= valid_mem[rd_idx];
      rd_data  <= valid_mem[rd_idx] ? data_mem[rd_idx] : '0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : prog_delay_line
// Description : Run-time programmable WIDTH-bit delay line with a valid flag.
//               A sample captured at enabled edge k appears on out/out_valid
//               after enabled edge k+D, D = clamp(delay, 1, MAX_DELAY).
//               Output is held at zero while the line fills (after reset or
//               flush) or settles (after a delay change).
// Ports       : clk       system clock, rising edge
//               rst_n     asynchronous active-low reset
//               en        clock enable, low freezes the line
//               flush     clear all in-flight samples (acts even when en=0)
//               delay     requested delay in enabled cycles
//               in        input sample
//               in_valid  input qualifier
//               out       delayed sample, zero when out_valid=0
//               out_valid delayed qualifier
// Revision    : 1.0 - initial release
// ============================================================================
module prog_delay_line
  import pdl_defs::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_DELAY = 16,
  parameter int DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [DW-1:0]    delay,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  localparam int            AW       = pdl_clog2(MAX_DELAY);
  localparam logic [AW-1:0] LAST_IDX = AW'(MAX_DELAY - 1);

  pdl_state_e    state_q, state_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;

  logic [DW-1:0] d_eff;
  logic [AW:0]   rd_sum;
  logic [AW-1:0] rd_idx;
  logic          wr_en;
  logic          rd_en;
  logic          rd_clr;

  assign d_eff = DW'(pdl_clamp(32'(delay), MAX_DELAY));

  // Read index = (wr_ptr - delay_q) mod MAX_DELAY. MAX_DELAY is added first
  // so the subtraction never underflows; delay_q = MAX_DELAY lands on the
  // entry being written, which read-before-write resolves to the old sample.
  assign rd_sum = {1'b0, wr_ptr_q} + (AW+1)'(MAX_DELAY) - (AW+1)'(delay_q);
  assign rd_idx = (rd_sum >= (AW+1)'(MAX_DELAY)) ? AW'(rd_sum - (AW+1)'(MAX_DELAY))
                                                 : AW'(rd_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= FILL;
      cnt_q    <= '0;
      delay_q  <= DW'(1);
      wr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      delay_q  <= delay_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    delay_d  = delay_q;
    wr_ptr_d = wr_ptr_q;
    wr_en    = 1'b0;
    rd_en    = 1'b0;
    rd_clr   = 1'b0;

    if (flush) begin
      // Flush owns the edge: no capture, pointer stays put, output zeroed.
      state_d = FILL;
      cnt_d   = '0;
      rd_clr  = 1'b1;
      if (en) begin
        delay_d = d_eff;
      end
    end else if (en) begin
      wr_en    = 1'b1;
      wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + 1'b1;
      if (d_eff != delay_q) begin
        // The change edge itself is the first of the D blanked edges.
        delay_d = d_eff;
        cnt_d   = d_eff;
        state_d = SETTLE;
        rd_clr  = 1'b1;
      end else begin
        case (state_q)
          FILL: begin
            // delay_q enabled edges since the fill began: the oldest
            // post-fill sample is now readable at this edge.
            if (cnt_q >= delay_q) begin
              state_d = RUN;
              rd_en   = 1'b1;
            end else begin
              cnt_d  = cnt_q + 1'b1;
              rd_clr = 1'b1;
            end
          end
          SETTLE: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q <= DW'(1)) begin
              cnt_d   = '0;
              state_d = RUN;
              rd_en   = 1'b1;
            end else begin
              rd_clr = 1'b1;
            end
          end
          RUN: begin
            rd_en = 1'b1;
          end
          default: begin
            state_d = FILL;
            cnt_d   = '0;
            rd_clr  = 1'b1;
          end
        endcase
      end
    end
  end

  pdl_ring_ram #(
    .WIDTH (WIDTH),
    .DEPTH (MAX_DELAY),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_ptr_q),
    .wr_data   (in),
    .wr_valid  (in_valid),
    .clr_valid (flush),
    .rd_en     (rd_en),
    .rd_clr    (rd_clr),
    .rd_idx    (rd_idx),
    .rd_data   (out),
    .rd_valid  (out_valid)
  );

endmodule
`default_nettype wire
